// File: rtl/mf8_ifetch.sv
// mf8 instruction fetch buffer: tracks one in-flight ROM read and queues returned
// words in a 2-entry FIFO, pausing the PC sequencer so the FIFO cannot overflow.
module mf8_ifetch (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] NPC,
  output logic [11:0] ROM_Addr,
  input  logic [15:0] ROM_Data,
  input  logic        Flush,
  input  logic        Stall,
  output logic [15:0] Inst,
  output logic [11:0] Inst_PC,
  output logic        Inst_Valid,
  output logic        Pause
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] PART  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  count;
  logic        inf;
  logic [11:0] inf_pc;
  logic [11:0] pc0;
  logic [11:0] pc1;
  logic [15:0] word0;
  logic [15:0] word1;

  logic        consume;
  logic        push;
  logic        pop;
  logic [2:0]  occupancy;

  always_comb begin
    ROM_Addr   = Reset ? '0 : NPC;
    Inst_Valid = ~Reset & (count != EMPTY);
    Inst       = Reset ? '0 : word0;
    Inst_PC    = Reset ? '0 : pc0;
    consume    = Inst_Valid & ~Stall;
    // A flush empties the FIFO outright, so neither a capture nor a pop applies.
    push       = inf & ~Flush;
    pop        = consume & ~Flush;
    occupancy  = {1'b0, count} + {2'b00, inf} - {2'b00, consume};
    Pause      = ~Reset & ~Flush & (occupancy >= 3'd2);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count  <= EMPTY;
      inf    <= 1'b1;
      inf_pc <= '0;
      pc0    <= '0;
      pc1    <= '0;
      word0  <= '0;
      word1  <= '0;
    end else begin
      inf    <= ~Pause | Flush;
      inf_pc <= NPC;
      if (Flush) begin
        count <= EMPTY;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == FULL) begin
              pc0   <= pc1;
              word0 <= word1;
              pc1   <= inf_pc;
              word1 <= ROM_Data;
            end else begin
              pc0   <= inf_pc;
              word0 <= ROM_Data;
            end
          end
          2'b10: begin
            if (count == EMPTY) begin
              pc0   <= inf_pc;
              word0 <= ROM_Data;
              count <= PART;
            end else begin
              pc1   <= inf_pc;
              word1 <= ROM_Data;
              count <= FULL;
            end
          end
          2'b01: begin
            pc0   <= pc1;
            word0 <= word1;
            count <= (count == FULL) ? PART : EMPTY;
          end
          default: ;
        endcase
      end
    end
  end

  fifo_no_overflow: assert property (@(posedge Clk) !(~Reset && push && !pop && count == FULL));

endmodule

// File: tb/tb_mf8_ifetch.sv
// Bench for mf8_ifetch: a PC-sequencer/ROM environment with randomized stall,
// flush and reset, checked by a queue-based scoreboard of issued fetches.
module tb_mf8_ifetch;

  logic        Clk;
  logic        Reset;
  logic [11:0] NPC;
  logic [11:0] ROM_Addr;
  logic [15:0] ROM_Data;
  logic        Flush;
  logic        Stall;
  logic [15:0] Inst;
  logic [11:0] Inst_PC;
  logic        Inst_Valid;
  logic        Pause;

  mf8_ifetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .NPC        (NPC),
    .ROM_Addr   (ROM_Addr),
    .ROM_Data   (ROM_Data),
    .Flush      (Flush),
    .Stall      (Stall),
    .Inst       (Inst),
    .Inst_PC    (Inst_PC),
    .Inst_Valid (Inst_Valid),
    .Pause      (Pause)
  );

  typedef struct {
    logic [11:0] pc;
    int          cyc;
  } exp_t;

  logic [15:0] rom [4096];
  exp_t        exp_q[$];
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [11:0] pc_reg;
  logic        after_rst;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) ROM_Data <= rom[ROM_Addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sequencer model: NPC advances unless paused, jumps on flush, restarts at 0 on reset.
  // Every fetch that is actually issued becomes an expected instruction, in order.
  task automatic step(input logic rst, input logic stl, input logic fl, input logic [11:0] tgt);
    logic        p;
    logic [11:0] npc_v;
    @(posedge Clk);
    cyc++;
    #1;
    Reset = rst;
    Stall = stl;
    Flush = fl;
    #1;
    p = Pause;
    if (rst)     npc_v = 12'($urandom);
    else if (fl) npc_v = tgt;
    else         npc_v = p ? pc_reg : pc_reg + 12'd1;
    NPC = npc_v;
    @(negedge Clk);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back('{12'h000, cyc});
      pc_reg = 12'h000;
    end else if (fl) begin
      exp_q.delete();
      exp_q.push_back('{tgt, cyc});
      pc_reg = tgt;
    end else begin
      if (!p) exp_q.push_back('{npc_v, cyc});
      pc_reg = npc_v;
    end
  endtask

  // Monitor: a fetch issued in cycle n is due at the head from cycle n+2 on.
  initial begin
    logic exp_v;
    logic cons;
    int   occ;
    after_rst = 1'b0;
    forever begin
      @(negedge Clk);
      if (cyc == 0) continue;
      if (Reset) begin
        chk("rst_valid", {31'b0, Inst_Valid}, 32'd0);
        chk("rst_inst", {16'b0, Inst}, 32'd0);
        chk("rst_pc", {20'b0, Inst_PC}, 32'd0);
        after_rst = 1'b1;
      end else begin
        if (after_rst) begin
          chk("post_rst_inst", {16'b0, Inst}, 32'd0);
          chk("post_rst_pc", {20'b0, Inst_PC}, 32'd0);
          chk("post_rst_pause", {31'b0, Pause}, 32'd0);
          after_rst = 1'b0;
        end
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
        chk("valid", {31'b0, Inst_Valid}, {31'b0, exp_v});
        if (exp_v && Inst_Valid) begin
          chk("inst_pc", {20'b0, Inst_PC}, {20'b0, exp_q[0].pc});
          chk("inst", {16'b0, Inst}, {16'b0, rom[exp_q[0].pc]});
        end
        cons = exp_v && !Stall;
        occ  = exp_q.size() - (cons ? 1 : 0);
        chk("pause", {31'b0, Pause}, {31'b0, (!Flush && occ >= 2)});
        if (cons) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic       rst;
    logic       fl;
    logic       stl;
    logic [11:0] tgt;
    int         r;
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    pc_reg   = 12'h000;
    Reset    = 1'b1;
    Stall    = 1'b0;
    Flush    = 1'b0;
    NPC      = 12'h000;
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h1111;
    rom[1] = 16'h2222;

    repeat (2) step(1'b1, 1'b0, 1'b0, 12'h000);
    repeat (6) step(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (4) step(1'b0, 1'b1, 1'b0, 12'h000);
    repeat (4) step(1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'h080);
    repeat (5) step(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b1, 12'h03e);
    repeat (6) step(1'b0, 1'b0, 1'b0, 12'h000);
    repeat (3) step(1'b0, 1'b1, 1'b0, 12'h000);
    step(1'b1, 1'b1, 1'b0, 12'h000);
    repeat (6) step(1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'hffc);
    repeat (10) step(1'b0, 1'b0, 1'b0, 12'h000);

    stl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 255);
      rst = (r == 0);
      fl  = !rst && (r < 16);
      tgt = ($urandom_range(0, 3) == 0) ? 12'hffe : 12'($urandom);
      if ($urandom_range(0, 5) == 0) stl = ~stl;
      step(rst, stl && ($urandom_range(0, 3) != 0), fl, tgt);
    end

    repeat (8) step(1'b0, 1'b0, 1'b0, 12'h000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
